// File: rtl/serial_magnitude_comparator.sv
// Serial magnitude comparator.
// Compares WIDTH-bit operands a and b MSB-first, DIGIT bits per clock, and reports
// a one-hot gt/eq/lt result through a valid/ready handshake.
//
// Parameters:
//   WIDTH  - operand width (>= 2, integer multiple of DIGIT)
//   DIGIT  - bits compared per cycle (1..WIDTH)
//   SIGNED - 0: unsigned compare, 1: two's-complement compare
//
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  - operand handshake; a, b sampled at the accept edge
//   out_valid / out_ready- result handshake; gt/eq/lt held until out_ready
//   gt, eq, lt           - one-hot result, all zero while out_valid is low
//   busy                 - comparison in progress
//
// Optional feature (macro SERIAL_CMP_EARLY_EXIT_EN): when defined, the comparison
// finishes in the cycle the first differing digit is found. Results are identical;
// only latency changes. Equal operands always take the full NDIG cycles.

module serial_magnitude_comparator #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGIT  = 1,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(NDIG - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MsbFlip =
        (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
    typedef enum logic [1:0] {DecEq, DecGt, DecLt} dec_e;

    state_e           state_q, state_d;
    dec_e             dec_q, dec_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [DIGIT-1:0] a_dig, b_dig;
    dec_e             dec_next;
    logic             last_dig;

    // Digit compare; the decision sticks once it leaves DecEq.
    always_comb begin
        a_dig    = a_sh_q[WIDTH-1 -: DIGIT];
        b_dig    = b_sh_q[WIDTH-1 -: DIGIT];
        dec_next = dec_q;
        if (dec_q == DecEq) begin
            if (a_dig > b_dig) begin
                dec_next = DecGt;
            end else if (a_dig < b_dig) begin
                dec_next = DecLt;
            end
        end
        last_dig = (cnt_q == LastCnt);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (dec_next != DecEq) begin
            last_dig = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a ^ MsbFlip;
                    b_sh_d     = b ^ MsbFlip;
                    dec_d      = DecEq;
                    cnt_d      = '0;
                    state_d    = StBusy;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StBusy: begin
                dec_d  = dec_next;
                a_sh_d = a_sh_q << DIGIT;
                b_sh_d = b_sh_q << DIGIT;
                cnt_d  = cnt_q + CW'(1);
                if (last_dig) begin
                    state_d     = StDone;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    gt_d        = (dec_next == DecGt);
                    eq_d        = (dec_next == DecEq);
                    lt_d        = (dec_next == DecLt);
                end
            end
            StDone: begin
                // in_ready rises only after this edge, so no same-edge accept.
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    gt_d        = 1'b0;
                    eq_d        = 1'b0;
                    lt_d        = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dec_q       <= DecEq;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: three instances
//   0: WIDTH=8 DIGIT=1 SIGNED=0
//   1: WIDTH=8 DIGIT=2 SIGNED=1
//   2: WIDTH=8 DIGIT=8 SIGNED=0
// Table-driven vectors plus hand-written backpressure, reset and back-to-back sequences.

module tb_serial_magnitude_comparator;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic       gt        [3];
    logic       eq        [3];
    logic       lt        [3];
    logic       busy      [3];
    logic [7:0] a         [3];
    logic [7:0] b         [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .gt(gt[0]), .eq(eq[0]), .lt(lt[0]), .busy(busy[0])
    );

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .gt(gt[1]), .eq(eq[1]), .lt(lt[1]), .busy(busy[1])
    );

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .a(a[2]), .b(b[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .gt(gt[2]), .eq(eq[2]), .lt(lt[2]), .busy(busy[2])
    );

    typedef struct {
        int         d;
        logic [7:0] av;
        logic [7:0] bv;
        logic [2:0] res;      // {gt, eq, lt}
        int         lat_off;
        int         lat_on;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] res_of(input int d);
        return {gt[d], eq[d], lt[d]};
    endfunction

    // Wait (bounded) for out_valid; returns edges counted from the current negedge.
    task automatic wait_result(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result(input int d, input string name);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk({name, " idle out_valid"}, out_valid[d], 0);
        chk({name, " idle result"}, res_of(d), 0);
        chk({name, " idle in_ready"}, in_ready[d], 1);
    endtask

    task automatic run_cmp(input int d, input logic [7:0] av, input logic [7:0] bv,
                           input logic [2:0] exp_res, input int exp_lat, input string name);
        int lat;
        @(negedge clk);
        chk({name, " in_ready"}, in_ready[d], 1);
        a[d] = av;
        b[d] = bv;
        in_valid[d] = 1'b1;
        @(negedge clk);
        in_valid[d] = 1'b0;
        chk({name, " busy"}, busy[d], (exp_lat > 0) ? 1 : 0);
        wait_result(d, lat);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, res_of(d), exp_res);
        release_result(d, name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        int pos [$];

        vecs[0] = '{0, 8'hA5, 8'hA5, 3'b010, 8, 8};
        vecs[1] = '{0, 8'h80, 8'h7F, 3'b100, 8, 1};
        vecs[2] = '{0, 8'h01, 8'h02, 3'b001, 8, 7};
        vecs[3] = '{1, 8'hFF, 8'h01, 3'b001, 4, 1};
        vecs[4] = '{1, 8'h80, 8'h80, 3'b010, 4, 4};
        vecs[5] = '{1, 8'h7F, 8'h80, 3'b100, 4, 1};
        vecs[6] = '{1, 8'hFE, 8'hFF, 3'b001, 4, 4};
        vecs[7] = '{2, 8'h00, 8'hFF, 3'b001, 1, 1};
        vecs[8] = '{2, 8'hFF, 8'h00, 3'b100, 1, 1};
        vecs[9] = '{2, 8'h5A, 8'h5A, 3'b010, 1, 1};

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            a[i]         = 8'h00;
            b[i]         = 8'h00;
        end
        rst_n = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d in_ready", i), in_ready[i], 1);
            chk($sformatf("reset%0d out_valid", i), out_valid[i], 0);
            chk($sformatf("reset%0d busy", i), busy[i], 0);
            chk($sformatf("reset%0d result", i), res_of(i), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_cmp(vecs[i].d, vecs[i].av, vecs[i].bv, vecs[i].res,
                    EARLY ? vecs[i].lat_on : vecs[i].lat_off, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles, stray in_valid ignored.
        @(negedge clk);
        a[0] = 8'h03;
        b[0] = 8'h09;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_result(0, lat);
        chk("bp latency", lat, EARLY ? 5 : 8);
        a[0] = 8'hFF;
        b[0] = 8'h00;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d valid", k), out_valid[0], 1);
            chk($sformatf("bp hold%0d result", k), res_of(0), 3'b001);
            chk($sformatf("bp hold%0d in_ready", k), in_ready[0], 0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bp release valid", out_valid[0], 0);
        chk("bp release busy", busy[0], 0);
        chk("bp release in_ready", in_ready[0], 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("bp next accept busy", busy[0], 1);
        chk("bp next accept in_ready", in_ready[0], 0);
        wait_result(0, lat);
        chk("bp next latency", lat, EARLY ? 1 : 8);
        chk("bp next result", res_of(0), 3'b100);
        release_result(0, "bp next");

        // Reset in the middle of BUSY.
        @(negedge clk);
        a[0] = 8'h10;
        b[0] = 8'h20;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset busy before", busy[0], 1);
        rst_n = 1'b0;
        #1;
        chk("midreset in_ready", in_ready[0], 1);
        chk("midreset busy", busy[0], 0);
        chk("midreset out_valid", out_valid[0], 0);
        chk("midreset result", res_of(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[0] || busy[0]) seen = 1;
        end
        chk("midreset no stale result", seen, 0);
        run_cmp(0, 8'h20, 8'h10, 3'b100, EARLY ? 3 : 8, "after reset");

        // Back-to-back on DIGIT=WIDTH: one result every 3 cycles.
        @(negedge clk);
        a[2] = 8'h00;
        b[2] = 8'hFF;
        in_valid[2]  = 1'b1;
        out_ready[2] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (out_valid[2]) begin
                pos.push_back(c);
                chk($sformatf("b2b result c%0d", c), res_of(2), 3'b001);
            end
        end
        in_valid[2]  = 1'b0;
        out_ready[2] = 1'b0;
        chk("b2b count", pos.size(), 3);
        if (pos.size() == 3) begin
            chk("b2b first", pos[0], 2);
            chk("b2b spacing1", pos[1] - pos[0], 3);
            chk("b2b spacing2", pos[2] - pos[1], 3);
        end
        repeat (2) @(negedge clk);
        chk("b2b final idle", in_ready[2], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
